// File: rtl/program_loader.sv
// program_loader: parses a byte stream and loads instruction and data memory.
//
// Stream format: a command byte, then for 0x00 (IMEM) / 0x01 (DMEM) a 16-bit
// little-endian word count N, then N little-endian words (4 bytes for IMEM,
// 8 bytes for DMEM). Command 0xFF starts the CPU. Any other command is an error.
//
// Ports:
//   clk, arst_n           clock, asynchronous active-low reset
//   in_valid/in_data      byte-stream source; a byte transfers on in_valid && in_ready
//   in_ready              loader can accept a byte this cycle
//   addr_ext/wen_ext/ren_ext/wdata_ext          IMEM write port (byte address, 32-bit word)
//   addr_ext_2/wen_ext_2/ren_ext_2/wdata_ext_2  DMEM write port (byte address, 64-bit word)
//   enable                CPU run enable, set after the RUN command
//   error                 sticky protocol error
module program_loader #(
    parameter int IMEM_DEPTH = 512,
    parameter int DMEM_DEPTH = 1024
) (
    input  logic        clk,
    input  logic        arst_n,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic [63:0] addr_ext,
    output logic        wen_ext,
    output logic        ren_ext,
    output logic [31:0] wdata_ext,
    output logic [63:0] addr_ext_2,
    output logic        wen_ext_2,
    output logic        ren_ext_2,
    output logic [63:0] wdata_ext_2,
    output logic        enable,
    output logic        error
);

    typedef enum logic [2:0] {
        S_IDLE, S_CNT_LO, S_CNT_HI, S_PAYLOAD, S_WRITE, S_RUN, S_ERR
    } state_t;

    localparam logic [16:0] IMEM_MAX = 17'(IMEM_DEPTH);
    localparam logic [16:0] DMEM_MAX = 17'(DMEM_DEPTH);

    state_t      r_state, w_next;
    logic        r_tgt;       // 0 = IMEM section, 1 = DMEM section
    logic [15:0] r_cnt;       // low byte of N while counting, then words remaining
    logic [2:0]  r_idx;       // byte position within the current word
    logic [63:0] r_asm;       // word assembly register
    logic [16:0] r_waddr;     // word index within the current section

    logic        w_acc;
    logic [15:0] w_n;
    logic        w_last;
    logic        w_too_big;
    logic [63:0] w_word;

    // Gated by reset so the source sees no ready while reset is held.
    assign in_ready = arst_n && (r_state == S_IDLE || r_state == S_CNT_LO ||
                                 r_state == S_CNT_HI || r_state == S_PAYLOAD);
    assign w_acc     = in_valid && in_ready;
    assign w_n       = {in_data, r_cnt[7:0]};
    assign w_last    = (r_idx == (r_tgt ? 3'd7 : 3'd3));
    assign w_too_big = r_tgt ? ({1'b0, w_n} > DMEM_MAX) : ({1'b0, w_n} > IMEM_MAX);

    assign wen_ext   = (r_state == S_WRITE) && !r_tgt;
    assign wen_ext_2 = (r_state == S_WRITE) &&  r_tgt;
    assign ren_ext   = 1'b0;
    assign ren_ext_2 = 1'b0;
    assign enable    = (r_state == S_RUN);
    assign error     = (r_state == S_ERR);

    // Assembled word including the byte being accepted this cycle, so the
    // write port is loaded at the same edge the last byte arrives.
    always_comb begin
        w_word = r_asm;
        w_word[{r_idx, 3'b000} +: 8] = in_data;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_acc) begin
                if (in_data == 8'h00 || in_data == 8'h01) w_next = S_CNT_LO;
                else if (in_data == 8'hFF)                w_next = S_RUN;
                else                                      w_next = S_ERR;
            end
            S_CNT_LO:  if (w_acc) w_next = S_CNT_HI;
            S_CNT_HI:  if (w_acc) begin
                if (w_n == 16'd0)   w_next = S_IDLE;
                else if (w_too_big) w_next = S_ERR;
                else                w_next = S_PAYLOAD;
            end
            S_PAYLOAD: if (w_acc && w_last) w_next = S_WRITE;
            S_WRITE:   w_next = (r_cnt == 16'd1) ? S_IDLE : S_PAYLOAD;
            S_RUN:     w_next = S_RUN;
            S_ERR:     w_next = S_ERR;
            default:   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_state     <= S_IDLE;
            r_tgt       <= 1'b0;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_asm       <= '0;
            r_waddr     <= '0;
            addr_ext    <= '0;
            wdata_ext   <= '0;
            addr_ext_2  <= '0;
            wdata_ext_2 <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE:   if (w_acc && in_data[7:1] == 7'd0) r_tgt <= in_data[0];
                S_CNT_LO: if (w_acc) r_cnt[7:0] <= in_data;
                S_CNT_HI: if (w_acc) begin
                    r_cnt   <= w_n;
                    r_waddr <= '0;
                    r_idx   <= '0;
                end
                S_PAYLOAD: if (w_acc) begin
                    r_asm <= w_word;
                    if (w_last) begin
                        r_idx <= '0;
                        if (r_tgt) begin
                            addr_ext_2  <= {44'd0, r_waddr, 3'b000};
                            wdata_ext_2 <= w_word;
                        end else begin
                            addr_ext    <= {45'd0, r_waddr, 2'b00};
                            wdata_ext   <= w_word[31:0];
                        end
                    end else begin
                        r_idx <= r_idx + 3'd1;
                    end
                end
                S_WRITE: begin
                    r_cnt   <= r_cnt - 16'd1;
                    r_waddr <= r_waddr + 17'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: a stream-level reference model predicts
// every memory write and the final run/error status; a monitor pops and checks
// each write as the DUT presents it.
module tb_program_loader;

    typedef logic [7:0] bq_t[$];
    typedef struct {
        bit          mem;
        logic [63:0] addr;
        logic [63:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        arst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready;
    logic [63:0] addr_ext, addr_ext_2, wdata_ext_2;
    logic [31:0] wdata_ext;
    logic        wen_ext, ren_ext, wen_ext_2, ren_ext_2, enable, error;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    program_loader #(.IMEM_DEPTH(512), .DMEM_DEPTH(1024)) dut (
        .clk(clk), .arst_n(arst_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready),
        .addr_ext(addr_ext), .wen_ext(wen_ext), .ren_ext(ren_ext), .wdata_ext(wdata_ext),
        .addr_ext_2(addr_ext_2), .wen_ext_2(wen_ext_2), .ren_ext_2(ren_ext_2),
        .wdata_ext_2(wdata_ext_2), .enable(enable), .error(error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Monitor: every write pulse must match the next predicted write.
    always @(negedge clk) begin
        if (arst_n && (wen_ext || wen_ext_2)) begin
            exp_t e;
            chk("wen_exclusive", {63'd0, wen_ext & wen_ext_2}, 64'd0);
            chk("ready_low_in_write", {63'd0, in_ready}, 64'd0);
            chk("ren_held_low", {62'd0, ren_ext, ren_ext_2}, 64'd0);
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_write: got write imem=%0b dmem=%0b want none",
                         wen_ext, wen_ext_2);
            end else begin
                e = sb.pop_front();
                chk("write_target", {63'd0, wen_ext_2}, {63'd0, e.mem});
                if (e.mem) begin
                    chk("dmem_addr", addr_ext_2, e.addr);
                    chk("dmem_data", wdata_ext_2, e.data);
                end else begin
                    chk("imem_addr", addr_ext, e.addr);
                    chk("imem_data", {32'd0, wdata_ext}, e.data);
                end
            end
        end
    end

    // Reference model: walks the byte stream section by section.
    // Returns 0 = idle/incomplete, 1 = run, 2 = error.
    function automatic int model(input bq_t q);
        int i, n, w;
        logic [7:0] c;
        exp_t e;
        i = 0;
        while (i < q.size()) begin
            c = q[i];
            i++;
            if (c == 8'hFF) return 1;
            if (c > 8'h01) return 2;
            if (i + 2 > q.size()) return 0;
            n = int'(q[i]) + 256 * int'(q[i+1]);
            i += 2;
            if (n > ((c == 8'h01) ? 1024 : 512)) return 2;
            w = (c == 8'h01) ? 8 : 4;
            for (int k = 0; k < n; k++) begin
                if (i + w > q.size()) return 0;
                e.mem  = c[0];
                e.addr = 64'(k * w);
                e.data = '0;
                for (int j = 0; j < w; j++) e.data[8*j +: 8] = q[i+j];
                i += w;
                sb.push_back(e);
            end
        end
        return 0;
    endfunction

    // mode 0: back-to-back, 1: valid toggles, 2: random idle gaps.
    task automatic send(input bq_t q, input int mode);
        int t, gap;
        foreach (q[b]) begin
            gap = (mode == 0) ? 0 : (mode == 1) ? 1 : int'($urandom_range(0, 2));
            in_valid = 1'b0;
            in_data  = 8'($urandom);
            repeat (gap) @(negedge clk);
            in_valid = 1'b1;
            in_data  = q[b];
            t = 0;
            while (!in_ready && t < 20) begin
                @(negedge clk);
                t++;
            end
            if (!in_ready) begin
                n_cmp++;
                n_bad++;
                $display("FAIL accept_timeout: byte %0d not accepted, want accepted", b);
                in_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        #2 arst_n = 1'b0;
        #1;
        chk("rst_ready", {63'd0, in_ready}, 64'd0);
        chk("rst_wen", {62'd0, wen_ext, wen_ext_2}, 64'd0);
        chk("rst_en_err", {62'd0, enable, error}, 64'd0);
        chk("rst_addr", addr_ext | addr_ext_2, 64'd0);
        chk("rst_wdata", {32'd0, wdata_ext} | wdata_ext_2, 64'd0);
        @(negedge clk);
        arst_n = 1'b1;
        #1;
        chk("ready_after_reset", {63'd0, in_ready}, 64'd1);
    endtask

    task automatic run(input string nm, input bq_t q, input int mode);
        int st;
        st = model(q);
        send(q, mode);
        chk({nm, "_enable"}, {63'd0, enable}, {63'd0, st == 1});
        chk({nm, "_error"},  {63'd0, error},  {63'd0, st == 2});
        repeat (3) @(negedge clk);
        chk({nm, "_writes_left"}, 64'(sb.size()), 64'd0);
        chk({nm, "_status_hold"}, {62'd0, enable, error}, {62'd0, st == 1, st == 2});
        sb.delete();
    endtask

    initial begin
        bq_t q;
        int  c, n, term;

        @(negedge clk);
        do_reset();
        run("two_imem", '{8'h00,8'h02,8'h00,8'h13,8'h00,8'h00,8'h00,8'h93,8'h00,8'h10,8'h00}, 2);
        do_reset();
        run("two_imem_toggle", '{8'h00,8'h02,8'h00,8'h13,8'h00,8'h00,8'h00,8'h93,8'h00,8'h10,8'h00}, 1);
        do_reset();
        run("dmem_run", '{8'h01,8'h01,8'h00,8'h88,8'h77,8'h66,8'h55,8'h44,8'h33,8'h22,8'h11,8'hFF}, 2);
        do_reset();
        run("imem_n513", '{8'h00,8'h01,8'h02}, 2);
        do_reset();
        run("bad_cmd", '{8'h42}, 0);
        do_reset();
        run("dmem_n1025", '{8'h01,8'h01,8'h04}, 0);
        do_reset();
        run("empty_run", '{8'h00,8'h00,8'h00,8'hFF}, 2);
        do_reset();
        run("overwrite", '{8'h00,8'h01,8'h00,8'h01,8'h02,8'h03,8'h04,
                           8'h00,8'h01,8'h00,8'h05,8'h06,8'h07,8'h08}, 2);

        // Reset mid-word discards the partial word.
        do_reset();
        send('{8'h00,8'h01,8'h00,8'h11,8'h22}, 2);
        do_reset();
        run("after_abort", '{8'h00,8'h01,8'h00,8'hAA,8'hBB,8'hCC,8'hDD}, 2);

        // Capacity boundaries.
        q = '{8'h00, 8'h00, 8'h02};
        for (int i = 0; i < 512 * 4; i++) q.push_back(8'($urandom));
        do_reset();
        run("imem_full", q, 0);
        q = '{8'h01, 8'h00, 8'h04};
        for (int i = 0; i < 1024 * 8; i++) q.push_back(8'($urandom));
        q.push_back(8'hFF);
        do_reset();
        run("dmem_full", q, 0);

        // Random multi-section streams with random terminators.
        for (int r = 0; r < 12; r++) begin
            q.delete();
            repeat ($urandom_range(1, 3)) begin
                c = int'($urandom_range(0, 1));
                n = int'($urandom_range(0, 4));
                q.push_back(8'(c));
                q.push_back(8'(n));
                q.push_back(8'h00);
                for (int i = 0; i < n * (c ? 8 : 4); i++) q.push_back(8'($urandom));
            end
            term = int'($urandom_range(0, 3));
            if (term == 0) q.push_back(8'hFF);
            else if (term == 1) q.push_back(8'($urandom_range(2, 254)));
            else if (term == 2) begin
                c = int'($urandom_range(0, 1));
                n = (c ? 1025 : 513) + int'($urandom_range(0, 100));
                q.push_back(8'(c));
                q.push_back(8'(n));
                q.push_back(8'(n >> 8));
            end
            do_reset();
            run($sformatf("rand%0d", r), q, 2);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
